// File: rtl/vga_timing_pkg.sv
// Shared timing constants and helpers for the VGA raster generator and its
// clients (pixel pipeline, DAC interface).
package vga_timing_pkg;

    localparam int X_W = 11;
    localparam int Y_W = 10;

    typedef struct packed {
        int h_active;
        int h_fp;
        int h_sync;
        int h_bp;
        int v_active;
        int v_fp;
        int v_sync;
        int v_bp;
        bit h_pol;
        bit v_pol;
    } timing_t;

    localparam timing_t SVGA_800x600_60 = '{
        h_active: 800, h_fp: 40, h_sync: 128, h_bp: 88,
        v_active: 600, v_fp: 1,  v_sync: 4,   v_bp: 23,
        h_pol: 1'b1,   v_pol: 1'b1
    };

    localparam timing_t VGA_640x480_60 = '{
        h_active: 640, h_fp: 16, h_sync: 96, h_bp: 48,
        v_active: 480, v_fp: 10, v_sync: 2,  v_bp: 33,
        h_pol: 1'b0,   v_pol: 1'b0
    };

    // True while val lies in the half-open window [lo, lo+len).
    function automatic logic in_window(input int val, input int lo, input int len);
        return (val >= lo) && (val < lo + len);
    endfunction

endpackage

// File: rtl/sync_bit.sv
// Two-flop synchroniser for a single asynchronous flag; clears on reset so the
// receiving domain always restarts from a known deasserted value.
module sync_bit (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Raster timing generator: free-running h/v counters gated by PLL lock, with
// every output decoded from the counters and registered one edge later.
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = SVGA_800x600_60.h_active,
    parameter int H_FP     = SVGA_800x600_60.h_fp,
    parameter int H_SYNC   = SVGA_800x600_60.h_sync,
    parameter int H_BP     = SVGA_800x600_60.h_bp,
    parameter int V_ACTIVE = SVGA_800x600_60.v_active,
    parameter int V_FP     = SVGA_800x600_60.v_fp,
    parameter int V_SYNC   = SVGA_800x600_60.v_sync,
    parameter int V_BP     = SVGA_800x600_60.v_bp,
    parameter bit H_POL    = SVGA_800x600_60.h_pol,
    parameter bit V_POL    = SVGA_800x600_60.v_pol
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           pll_locked,
    output logic           hsync,
    output logic           vsync,
    output logic           de,
    output logic [X_W-1:0] x,
    output logic [Y_W-1:0] y,
    output logic           line_start,
    output logic           frame_start,
    output logic           running
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [X_W-1:0] H_LAST = X_W'(H_TOTAL - 1);
    localparam logic [Y_W-1:0] V_LAST = Y_W'(V_TOTAL - 1);

    if (H_TOTAL > (1 << X_W)) begin : g_h_total_chk
        $error("vga_timing_gen: H_TOTAL does not fit the x counter");
    end
    if (V_TOTAL > (1 << Y_W)) begin : g_v_total_chk
        $error("vga_timing_gen: V_TOTAL does not fit the y counter");
    end

    logic           lock_s;
    logic           run;
    logic [X_W-1:0] h_cnt;
    logic [X_W-1:0] h_nxt;
    logic [Y_W-1:0] v_cnt;
    logic [Y_W-1:0] v_nxt;
    logic           h_wrap;
    logic           de_d;
    logic           hs_on;
    logic           vs_on;
    logic           ls_d;
    logic           fs_d;

    sync_bit u_lock_sync (
        .clk (clk),
        .rst (rst),
        .d   (pll_locked),
        .q   (lock_s)
    );

    assign run = lock_s & ~rst;

    always_comb begin
        h_wrap = (h_cnt == H_LAST);
        h_nxt  = h_wrap ? '0 : h_cnt + X_W'(1);
        v_nxt  = v_cnt;
        if (h_wrap) begin
            v_nxt = (v_cnt == V_LAST) ? '0 : v_cnt + Y_W'(1);
        end
        de_d  = (int'(h_cnt) < H_ACTIVE) && (int'(v_cnt) < V_ACTIVE);
        hs_on = in_window(int'(h_cnt), H_ACTIVE + H_FP, H_SYNC);
        vs_on = in_window(int'(v_cnt), V_ACTIVE + V_FP, V_SYNC);
        ls_d  = (h_cnt == '0) && (int'(v_cnt) < V_ACTIVE);
        fs_d  = (h_cnt == '0) && (v_cnt == '0);
    end

    // Losing run returns straight to the frame origin; no partial frame is finished.
    always_ff @(posedge clk) begin
        if (!run) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            hsync       <= ~H_POL;
            vsync       <= ~V_POL;
            de          <= 1'b0;
            x           <= '0;
            y           <= '0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            running     <= 1'b0;
        end else begin
            h_cnt       <= h_nxt;
            v_cnt       <= v_nxt;
            hsync       <= hs_on ? H_POL : ~H_POL;
            vsync       <= vs_on ? V_POL : ~V_POL;
            de          <= de_d;
            x           <= h_cnt;
            y           <= v_cnt;
            line_start  <= ls_d;
            frame_start <= fs_d;
            running     <= 1'b1;
        end
    end

endmodule
